// File: rtl/seg_scan_capture.sv
// seg_scan_capture: receive-side monitor for the multiplexed 7-segment bus.
// The display scan is registered once, each digit slot is decoded back to
// BCD, and complete HH:MM:SS frames are published with a one-cycle strobe.
// Malformed or stalled scans are reported as frame errors.
//
// Optional feature macro: SEG_CAPTURE_CONFIRM_EN
//   defined   -> a frame is published only when it equals the previous
//                completely assembled frame (two identical scans in a row)
//   undefined -> every complete frame is published
//
// Ports:
//   clk, rst     clock; asynchronous active-high reset
//   seg_com      digit select, active-low (slot 0 = MSB)
//   seg_data     segment pattern {a,b,c,d,e,f,g,dp}, active-high
//   time_bcd     {h_ten,h_one,m_ten,m_one,s_ten,s_one} of the last published frame
//   frame_valid  one-cycle pulse, time_bcd updated on this cycle
//   frame_err    one-cycle pulse on an aborted or corrupt frame
//   range_err    level, last published frame holds an impossible time
//   frame_cnt    published frames (wraps)
//   err_cnt      frame_err pulses (saturates)
module seg_scan_capture #(
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       seg_com,
    input  logic [7:0]       seg_data,
    output logic [23:0]      time_bcd,
    output logic             frame_valid,
    output logic             frame_err,
    output logic             range_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);
    localparam logic [0:0] IDLE    = 1'b0;
    localparam logic [0:0] COLLECT = 1'b1;
    localparam int         TMR_W   = $clog2(TIMEOUT_CYC + 1);

    typedef struct packed {
        logic       blank;
        logic       bad_com;
        logic [2:0] slot;
        logic       bad_seg;
        logic [3:0] digit;
    } sample_t;

    logic [7:0]       com_q, data_q;
    sample_t          smp;
    logic [0:0]       state;
    logic [2:0]       exp_slot, last_slot;
    logic [TMR_W-1:0] timer, timer_inc;
    logic [3:0]       dig [0:4];
    logic [23:0]      frame;
    logic             start0, advance, tick, abort, complete, publish, frame_rng;
    logic             unused_dp;

    assign unused_dp = data_q[0];

    // Slot and digit decode of the registered bus sample.
    always_comb begin
        smp = '0;
        case (com_q)
            8'h7F:   smp.slot = 3'd0;
            8'hBF:   smp.slot = 3'd1;
            8'hDF:   smp.slot = 3'd2;
            8'hEF:   smp.slot = 3'd3;
            8'hF7:   smp.slot = 3'd4;
            8'hFB:   smp.slot = 3'd5;
            8'hFF:   smp.blank = 1'b1;
            default: smp.bad_com = 1'b1;
        endcase
        case (data_q[7:1])
            7'b1111110: smp.digit = 4'd0;
            7'b0110000: smp.digit = 4'd1;
            7'b1101101: smp.digit = 4'd2;
            7'b1111001: smp.digit = 4'd3;
            7'b0110011: smp.digit = 4'd4;
            7'b1011011: smp.digit = 4'd5;
            7'b1011111: smp.digit = 4'd6;
            7'b1110000: smp.digit = 4'd7;
            7'b1111111: smp.digit = 4'd8;
            7'b1111011: smp.digit = 4'd9;
            default:    smp.bad_seg = 1'b1;
        endcase
    end

    assign start0    = !smp.blank && !smp.bad_com && !smp.bad_seg && (smp.slot == 3'd0);
    assign last_slot = exp_slot - 3'd1;
    assign timer_inc = timer + 1'b1;

    // Classify the sample while collecting. Blank cycles and accepted repeats
    // of the last slot both count toward the inter-slot timeout.
    always_comb begin
        advance = 1'b0;
        tick    = 1'b0;
        abort   = 1'b0;
        if (state == COLLECT) begin
            if (smp.bad_com)
                abort = 1'b1;
            else if (smp.blank)
                tick = 1'b1;
            else if (smp.bad_seg)
                abort = 1'b1;
            else if (smp.slot == exp_slot)
                advance = 1'b1;
            else if (smp.slot == last_slot && smp.digit == dig[last_slot])
                tick = 1'b1;
            else
                abort = 1'b1;
            if (tick && timer_inc == TMR_W'(TIMEOUT_CYC))
                abort = 1'b1;
        end
    end

    // Slot 5 comes straight from the current sample; slots 0-4 are latched.
    assign frame    = {dig[0], dig[1], dig[2], dig[3], dig[4], smp.digit};
    assign complete = advance && (smp.slot == 3'd5);
    assign frame_rng = (frame[23:20] > 4'd2) ||
                       (frame[23:20] == 4'd2 && frame[19:16] > 4'd3) ||
                       (frame[15:12] > 4'd5) || (frame[7:4] > 4'd5);

`ifdef SEG_CAPTURE_CONFIRM_EN
    logic [23:0] cand;
    logic        cand_vld;

    // Every complete frame becomes the candidate for the next comparison.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand     <= '0;
            cand_vld <= 1'b0;
        end else if (complete) begin
            cand     <= frame;
            cand_vld <= 1'b1;
        end
    end

    assign publish = complete && cand_vld && (cand == frame);
`else
    assign publish = complete;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            com_q       <= 8'hFF;
            data_q      <= '0;
            state       <= IDLE;
            exp_slot    <= '0;
            timer       <= '0;
            for (int i = 0; i < 5; i++) dig[i] <= '0;
            time_bcd    <= '0;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            range_err   <= 1'b0;
            frame_cnt   <= '0;
            err_cnt     <= '0;
        end else begin
            com_q       <= seg_com;
            data_q      <= seg_data;
            frame_valid <= 1'b0;
            frame_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (start0) begin
                        dig[0]   <= smp.digit;
                        exp_slot <= 3'd1;
                        timer    <= '0;
                        state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (abort) begin
                        frame_err <= 1'b1;
                        if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                        // A valid slot 0 that kills a frame also opens the next one.
                        if (start0) begin
                            dig[0]   <= smp.digit;
                            exp_slot <= 3'd1;
                            timer    <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (advance) begin
                        timer <= '0;
                        if (smp.slot == 3'd5) begin
                            state <= IDLE;
                        end else begin
                            dig[smp.slot] <= smp.digit;
                            exp_slot      <= exp_slot + 3'd1;
                        end
                    end else if (tick) begin
                        timer <= timer_inc;
                    end
                end
                default: state <= IDLE;
            endcase
            if (publish) begin
                time_bcd    <= frame;
                frame_valid <= 1'b1;
                frame_cnt   <= frame_cnt + 1'b1;
                range_err   <= frame_rng;
            end
        end
    end
endmodule

// File: tb/tb_seg_scan_capture.sv
// Self-checking bench for seg_scan_capture. Times are described as plain
// hours/minutes/seconds; the reference model derives the expected BCD word,
// range flag and counters from those numbers.
`timescale 1ns/1ps
module tb_seg_scan_capture;
    localparam int TO = 16;
    localparam int CW = 8;
`ifdef SEG_CAPTURE_CONFIRM_EN
    localparam bit CONFIRM = 1'b1;
`else
    localparam bit CONFIRM = 1'b0;
`endif
    localparam int REPS = CONFIRM ? 2 : 1;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    seg_com, seg_data;
    logic [23:0]   time_bcd;
    logic          frame_valid, frame_err, range_err;
    logic [CW-1:0] frame_cnt, err_cnt;

    seg_scan_capture #(.TIMEOUT_CYC(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .seg_com(seg_com), .seg_data(seg_data),
        .time_bcd(time_bcd), .frame_valid(frame_valid), .frame_err(frame_err),
        .range_err(range_err), .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitor, sampled on the inactive edge.
    int fv_n = 0, fe_n = 0, fv_cyc = -1, fe_cyc = -1;
    always @(negedge clk) begin
        if (frame_valid) begin fv_n <= fv_n + 1; fv_cyc <= cyc; end
        if (frame_err)   begin fe_n <= fe_n + 1; fe_cyc <= cyc; end
    end

    int total = 0, bad = 0;

    // Reference model state
    logic [23:0] m_bcd, m_cand;
    bit          m_rng, m_cand_v;
    int          m_fcnt, m_ecnt;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [23:0] bcd_of(input int h, input int m, input int s);
        return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    endfunction

    task automatic m_reset();
        m_bcd = '0; m_cand = '0; m_rng = 0; m_cand_v = 0; m_fcnt = 0; m_ecnt = 0;
    endtask

    task automatic m_complete(input int h, input int m, input int s, output bit pub);
        logic [23:0] f;
        f = bcd_of(h, m, s);
        pub = !CONFIRM || (m_cand_v && m_cand == f);
        m_cand = f;
        m_cand_v = 1;
        if (pub) begin
            m_bcd  = f;
            m_rng  = (h > 23) || (m > 59) || (s > 59);
            m_fcnt = (m_fcnt + 1) % (1 << CW);
        end
    endtask

    task automatic m_err();
        if (m_ecnt < (1 << CW) - 1) m_ecnt++;
    endtask

    function automatic logic [6:0] pat(input int d);
        case (d)
            0: return 7'b1111110;  1: return 7'b0110000;  2: return 7'b1101101;
            3: return 7'b1111001;  4: return 7'b0110011;  5: return 7'b1011011;
            6: return 7'b1011111;  7: return 7'b1110000;  8: return 7'b1111111;
            default: return 7'b1111011;
        endcase
    endfunction

    function automatic logic [7:0] com_of(input int sl);
        logic [7:0] one;
        one = 8'h80;
        return ~(one >> sl);
    endfunction

    task automatic drv(input logic [7:0] c, input logic [7:0] d);
        @(negedge clk);
        seg_com  = c;
        seg_data = d;
    endtask

    task automatic slot(input int sl, input int d);
        drv(com_of(sl), {pat(d), 1'($urandom)});
    endtask

    task automatic blanks(input int n);
        for (int i = 0; i < n; i++) drv(8'hFF, 8'($urandom));
    endtask

    task automatic scan(input int h, input int m, input int s, input int maxhold,
                        input int maxgap, input int tail, output int c5);
        int d[6];
        int hold;
        d = '{h / 10, h % 10, m / 10, m % 10, s / 10, s % 10};
        c5 = 0;
        for (int sl = 0; sl < 6; sl++) begin
            hold = int'($urandom_range(maxhold, 1));
            for (int k = 0; k < hold; k++) begin
                slot(sl, d[sl]);
                if (sl == 5 && k == 0) c5 = cyc;
            end
            if (sl < 5) blanks(int'($urandom_range(maxgap, 0)));
        end
        blanks(tail);
    endtask

    task automatic state_chk(input string tag);
        chk({tag, "_bcd"},  32'(time_bcd),  32'(m_bcd));
        chk({tag, "_rng"},  32'(range_err), 32'(m_rng));
        chk({tag, "_fcnt"}, 32'(frame_cnt), 32'(m_fcnt));
        chk({tag, "_ecnt"}, 32'(err_cnt),   32'(m_ecnt));
    endtask

    task automatic frame_chk(input string tag, input int h, input int m, input int s,
                             input int maxhold, input int maxgap);
        int fv0, fe0, c5;
        bit pub;
        fv0 = fv_n; fe0 = fe_n;
        scan(h, m, s, maxhold, maxgap, 2, c5);
        blanks(3);
        m_complete(h, m, s, pub);
        chk({tag, "_fv"}, 32'(fv_n - fv0), 32'(pub));
        if (pub) chk({tag, "_lat"}, 32'(fv_cyc - c5), 32'd2);
        chk({tag, "_fe"}, 32'(fe_n - fe0), 32'd0);
        state_chk(tag);
    endtask

    task automatic frame(input string tag, input int h, input int m, input int s,
                         input int maxhold, input int maxgap);
        for (int r = 0; r < REPS; r++) frame_chk(tag, h, m, s, maxhold, maxgap);
    endtask

    // Caller drives the aborting sample at cycle c and at least 3 blanks after.
    task automatic err_chk(input string tag, input int fe0, input int fv0, input int c);
        m_err();
        chk({tag, "_fe"},    32'(fe_n - fe0), 32'd1);
        chk({tag, "_fecyc"}, 32'(fe_cyc - c), 32'd2);
        chk({tag, "_fv"},    32'(fv_n - fv0), 32'd0);
        state_chk(tag);
    endtask

    task automatic zero_chk(input string tag);
        chk({tag, "_bcd"},  32'(time_bcd),    32'd0);
        chk({tag, "_fv"},   32'(frame_valid), 32'd0);
        chk({tag, "_fe"},   32'(frame_err),   32'd0);
        chk({tag, "_rng"},  32'(range_err),   32'd0);
        chk({tag, "_fcnt"}, 32'(frame_cnt),   32'd0);
        chk({tag, "_ecnt"}, 32'(err_cnt),     32'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fv0, fe0, c, k, kind, h, m, s;
        logic [7:0] badc [5];
        badc = '{8'h00, 8'h3F, 8'hFE, 8'hFD, 8'h7E};

        rst = 1'b1; seg_com = 8'hFF; seg_data = 8'h00;
        m_reset();
        repeat (3) @(negedge clk);
        zero_chk("reset");
        rst = 1'b0;
        blanks(2);

        // Clean 12:34:56
        frame("clean", 12, 34, 56, 1, 0);
        chk("clean_lit", 32'(time_bcd), 32'h123456);
        chk("clean_cnt_lit", 32'(frame_cnt), 32'd1);

        // Slot 2 skipped
        fv0 = fv_n; fe0 = fe_n;
        slot(0, 1); slot(1, 2); slot(3, 4); c = cyc;
        blanks(4);
        err_chk("skip", fe0, fv0, c);

        // Invalid digit on slot 4, then 23:59:59
        fv0 = fv_n; fe0 = fe_n;
        slot(0, 2); slot(1, 3); slot(2, 5); slot(3, 9);
        drv(com_of(4), 8'b0000_0010); c = cyc;
        blanks(4);
        err_chk("badseg", fe0, fv0, c);
        frame("t235959", 23, 59, 59, 1, 0);
        chk("t235959_lit", 32'(time_bcd), 32'h235959);

        // Out-of-range then clean zero time
        frame("rng_hi", 24, 61, 0, 2, 2);
        chk("rng_hi_lit", 32'(range_err), 32'd1);
        frame("rng_lo", 0, 0, 0, 2, 2);
        chk("rng_lo_lit", 32'(range_err), 32'd0);

        // Timeout: 20 blanks after slot 2, abort on the 16th
        fv0 = fv_n; fe0 = fe_n;
        slot(0, 1); slot(1, 1); slot(2, 4);
        blanks(TO - 1);
        drv(8'hFF, 8'h00); c = cyc;
        blanks(20 - TO);
        err_chk("timeout", fe0, fv0, c);
        frame("after_to", 9, 8, 7, 1, 0);

        // Slot 0 in mid-frame aborts and restarts in the same cycle
        fv0 = fv_n; fe0 = fe_n;
        slot(0, 9); slot(1, 8); slot(2, 7);
        slot(0, 0); c = cyc;
        slot(1, 7); slot(2, 4); slot(3, 5); slot(4, 1); slot(5, 2);
        blanks(4);
        m_err();
        begin
            bit pub;
            m_complete(7, 45, 12, pub);
            chk("restart_fv", 32'(fv_n - fv0), 32'(pub));
        end
        chk("restart_fe", 32'(fe_n - fe0), 32'd1);
        chk("restart_fecyc", 32'(fe_cyc - c), 32'd2);
        state_chk("restart");

        // Repeat of the last slot: same digit accepted, different digit aborts
        fv0 = fv_n; fe0 = fe_n;
        slot(0, 1); slot(0, 1); slot(1, 2); slot(1, 3); c = cyc;
        blanks(4);
        err_chk("rep_diff", fe0, fv0, c);

        // Confirmation: first 01:02:03 only publishes without the confirm option
        fv0 = fv_n;
        frame_chk("conf1", 1, 2, 3, 1, 0);
        chk("conf1_lit", 32'(fv_n - fv0), CONFIRM ? 32'd0 : 32'd1);
        fv0 = fv_n;
        frame_chk("conf2", 1, 2, 3, 1, 0);
        chk("conf2_lit", 32'(fv_n - fv0), 32'd1);

        // Reset in mid-frame
        slot(0, 1); slot(1, 1); slot(2, 1); slot(3, 1);
        @(negedge clk);
        rst = 1'b1; seg_com = 8'hFF;
        @(negedge clk);
        zero_chk("midrst");
        m_reset();
        rst = 1'b0;
        blanks(4);
        frame("post_rst", 10, 20, 30, 1, 0);
        chk("post_rst_cnt_lit", 32'(frame_cnt), 32'd1);

        // Randomized mix of clean and broken scans
        for (int it = 0; it < 24; it++) begin
            kind = int'($urandom_range(3, 0));
            if (kind < 2) begin
                h = int'($urandom_range(99, 0));
                m = int'($urandom_range(99, 0));
                s = int'($urandom_range(99, 0));
                frame("rnd_ok", h, m, s, 3, 3);
            end else begin
                fv0 = fv_n; fe0 = fe_n;
                k = int'($urandom_range(4, 1));
                for (int sl = 0; sl < k; sl++) slot(sl, int'($urandom_range(9, 0)));
                if (kind == 2) slot(k + 1, int'($urandom_range(9, 0)));
                else drv(badc[$urandom_range(4, 0)], 8'($urandom));
                c = cyc;
                blanks(4);
                err_chk(kind == 2 ? "rnd_skip" : "rnd_badcom", fe0, fv0, c);
            end
        end

        // err_cnt saturation
        fe0 = fe_n;
        for (int i = 0; i < 260; i++) begin
            slot(0, 5);
            drv(8'h00, 8'h00);
            m_err();
        end
        blanks(4);
        chk("sat_pulses", 32'(fe_n - fe0), 32'd260);
        chk("sat_ecnt", 32'(err_cnt), 32'(m_ecnt));
        chk("sat_lit", 32'(err_cnt), 32'd255);

        // frame_cnt wrap with back-to-back scans
        for (int i = 0; i < 256; i++) begin
            bit pub;
            scan(11, 22, 33, 1, 0, 0, c);
            m_complete(11, 22, 33, pub);
        end
        blanks(4);
        state_chk("wrap");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
